// File: rtl/xadc_drp_arbiter_pkg.sv
// Shared types and constants for the XADC DRP arbiter.
package xadc_drp_arbiter_pkg;

  typedef logic [6:0] xadc_drp_addr_t;

  localparam int unsigned XADC_DRP_ADDR_WIDTH      = $bits(xadc_drp_addr_t);
  localparam int unsigned XADC_DRP_DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DRDY = 2'd1,
    ST_RESPOND   = 2'd2
  } xadc_drp_arb_state_t;

endpackage

// File: rtl/drp_rr_arbiter.sv
// Combinational round-robin winner search: first asserted request found
// searching upward (modulo NUM_REQ) from the slot after the pointer.
module drp_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  // Scan the NUM_REQ slots starting at pointer+1, keep the first hit.
  always_comb begin
    int unsigned k;
    logic [IDX_W-1:0] w_k;
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    k       = 0;
    w_k     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      k   = (32'(i_ptr) + off) % NUM_REQ;
      w_k = IDX_W'(k);
      if (!o_found && i_req[w_k]) begin
        o_found    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP port between NUM_REQ clients,
// one transaction in flight, with a drdy timeout guard.
module xadc_drp_arbiter
  import xadc_drp_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = XADC_DRP_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = XADC_DRP_DEFAULT_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            drp_daddr,
  output logic                             drp_den,
  output logic                             drp_dwe,
  output logic [DATA_WIDTH-1:0]            drp_di,
  input  logic                             drp_drdy,
  input  logic [DATA_WIDTH-1:0]            drp_do,
  output logic                             busy,
  output logic [7:0]                       timeout_count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  xadc_drp_arb_state_t     r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_gnt;
  logic [TMR_W-1:0]        r_timer;
  logic [ADDR_WIDTH-1:0]   r_daddr;
  logic                    r_den;
  logic                    r_dwe;
  logic [DATA_WIDTH-1:0]   r_di;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    r_rsp_err;
  logic [7:0]              r_tocnt;

  logic [NUM_REQ-1:0]      w_gnt_oh;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_found;
  logic [NUM_REQ-1:0]      w_rsp_valid;

  drp_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt_oh),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign req_ready     = (r_state == ST_IDLE) ? w_gnt_oh : '0;
  assign busy          = (r_state != ST_IDLE);
  assign drp_daddr     = r_daddr;
  assign drp_den       = r_den;
  assign drp_dwe       = r_dwe;
  assign drp_di        = r_di;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;
  assign timeout_count = r_tocnt;
  assign rsp_valid     = w_rsp_valid;

  // Response pulse goes only to the lane that owns the finished transaction.
  always_comb begin
    w_rsp_valid = '0;
    if (r_state == ST_RESPOND) w_rsp_valid[r_gnt] = 1'b1;
  end

  // Transaction FSM: accept, wait for drdy or timeout, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_gnt      <= '0;
      r_timer    <= '0;
      r_daddr    <= '0;
      r_den      <= 1'b0;
      r_dwe      <= 1'b0;
      r_di       <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_tocnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_daddr <= req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_dwe   <= req_we[w_idx];
            r_di    <= req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
            r_den   <= 1'b1;
            r_gnt   <= w_idx;
            r_ptr   <= w_idx;
            r_timer <= '0;
            r_state <= ST_WAIT_DRDY;
          end
        end
        ST_WAIT_DRDY: begin
          r_den   <= 1'b0;
          r_timer <= r_timer + 1'b1;
          // drdy is checked first so it wins over a coincident timeout
          if (drp_drdy) begin
            r_rsp_data <= r_dwe ? '0 : drp_do;
            r_rsp_err  <= 1'b0;
            r_state    <= ST_RESPOND;
          end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            if (r_tocnt != 8'hFF) r_tocnt <= r_tocnt + 8'd1;
            r_state    <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Scoreboard bench for xadc_drp_arbiter with a delay-programmable DRP responder.
module tb_xadc_drp_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_addr;
  logic [1:0]  req_we;
  logic [31:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic        busy;
  logic [7:0]  timeout_count;

  typedef struct {
    int          lane;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] do_q[$];
  int          grant_log[$];
  int          drp_delay;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rsp = 0;
  int          cyc   = 0;
  exp_t        e;

  xadc_drp_arbiter #(
    .NUM_REQ        (2),
    .ADDR_WIDTH     (7),
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_we        (req_we),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .drp_daddr     (drp_daddr),
    .drp_den       (drp_den),
    .drp_dwe       (drp_dwe),
    .drp_di        (drp_di),
    .drp_drdy      (drp_drdy),
    .drp_do        (drp_do),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DRP model: after seeing den, waits drp_delay cycles then pulses drdy.
  initial begin : responder
    int          d;
    logic [15:0] v;
    drp_drdy = 1'b0;
    drp_do   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && drp_den && drp_delay >= 0) begin
        d = drp_delay;
        v = (do_q.size() > 0) ? do_q.pop_front() : 16'hDEAD;
        repeat (d) @(negedge clk);
        drp_drdy = 1'b1;
        drp_do   = v;
        @(negedge clk);
        drp_drdy = 1'b0;
      end
    end
  end

  // Response monitor: every rsp_valid pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_ready & req_valid)) grant_log.push_back(req_ready[1] ? 1 : 0);
      if (drp_den) begin
        n_cmp++;
        if (!busy) begin
          n_bad++;
          $display("FAIL den_outside_txn: den=1 busy=%0b required busy=1", busy);
        end
      end
      if (rsp_valid != 2'b00) begin
        n_rsp++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL stray_rsp: rsp_valid=%b data=%h err=%b required no response",
                   rsp_valid, rsp_data, rsp_err);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== (2'b01 << e.lane) || rsp_data !== e.data || rsp_err !== e.err) begin
            n_bad++;
            $display("FAIL rsp: valid=%b data=%h err=%b required valid=%b data=%h err=%b",
                     rsp_valid, rsp_data, rsp_err, 2'(2'b01 << e.lane), e.data, e.err);
          end
        end
      end
    end
  end

  task automatic send(input int lane, input logic [6:0] a, input logic we,
                      input logic [15:0] wd, output int waited, output int acc);
    @(posedge clk); #1;
    req_valid[lane]           = 1'b1;
    req_addr[lane*7 +: 7]     = a;
    req_we[lane]              = we;
    req_wdata[lane*16 +: 16]  = wd;
    waited = -1;
    acc    = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[lane]) begin
        waited = i;
        acc    = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[lane] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, drp_den, drp_dwe, drp_daddr, drp_di, rsp_valid, rsp_err, rsp_data,
         req_ready, timeout_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_in: busy=%b den=%b addr=%h rsp_valid=%b tc=%0d required all 0",
               busy, drp_den, drp_daddr, rsp_valid, timeout_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, drp_den, rsp_valid, timeout_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: busy=%b den=%b rsp_valid=%b tc=%0d required all 0",
               busy, drp_den, rsp_valid, timeout_count);
    end
  endtask

  task automatic test_single_read();
    int w, acc;
    bit ok;
    drp_delay = 3;
    do_q.push_back(16'h8A30);
    sb.push_back('{0, 16'h8A30, 1'b0});
    send(0, 7'h14, 1'b0, 16'h0, w, acc);
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL read_ready_latency: waited=%0d required 0", w);
    end
    @(negedge clk);
    n_cmp++;
    if (drp_den !== 1'b1 || drp_daddr !== 7'h14 || drp_dwe !== 1'b0) begin
      n_bad++;
      $display("FAIL read_den: den=%b addr=%h we=%b required 1 14 0", drp_den, drp_daddr, drp_dwe);
    end
    @(negedge clk);
    n_cmp++;
    if (drp_den !== 1'b0) begin
      n_bad++;
      $display("FAIL read_den_pulse: den=%b required 0", drp_den);
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL read_done: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_write();
    int w, acc;
    bit ok;
    drp_delay = 2;
    do_q.push_back(16'h5555);
    sb.push_back('{1, 16'h0000, 1'b0});
    send(1, 7'h41, 1'b1, 16'h2000, w, acc);
    @(negedge clk);
    n_cmp++;
    if (drp_den !== 1'b1 || drp_dwe !== 1'b1 || drp_di !== 16'h2000 || drp_daddr !== 7'h41) begin
      n_bad++;
      $display("FAIL write_den: den=%b we=%b di=%h addr=%h required 1 1 2000 41",
               drp_den, drp_dwe, drp_di, drp_daddr);
    end
    @(negedge clk);
    n_cmp++;
    if (drp_den !== 1'b0 || drp_dwe !== 1'b1 || drp_di !== 16'h2000) begin
      n_bad++;
      $display("FAIL write_hold: den=%b we=%b di=%h required 0 1 2000", drp_den, drp_dwe, drp_di);
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL write_done: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    drp_delay = 1;
    grant_log.delete();
    for (int k = 0; k < 6; k++) begin
      do_q.push_back(16'h1000 + 16'(k));
      sb.push_back('{k % 2, 16'h1000 + 16'(k), 1'b0});
    end
    @(posedge clk); #1;
    req_addr  = {7'h11, 7'h10};
    req_we    = 2'b00;
    req_valid = 2'b11;
    for (int i = 0; i < 400 && grant_log.size() < 6; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle(ok);
    n_cmp++;
    if (!ok || grant_log.size() != 6) begin
      n_bad++;
      $display("FAIL rr_count: grants=%0d done=%0b required 6 1", grant_log.size(), ok);
    end
    for (int k = 0; k < grant_log.size() && k < 6; k++) begin
      n_cmp++;
      if (grant_log[k] != k % 2) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: lane=%0d required %0d", k, grant_log[k], k % 2);
      end
    end
  endtask

  task automatic test_timeout();
    int w, acc, lat, nr;
    bit ok, seen;
    drp_delay = -1;
    sb.push_back('{0, 16'h0000, 1'b1});
    send(0, 7'h03, 1'b0, 16'h0, w, acc);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        seen = 1'b1;
        lat  = cyc - acc;
        break;
      end
    end
    n_cmp++;
    if (!seen || lat != TO + 1) begin
      n_bad++;
      $display("FAIL timeout_latency: seen=%0b latency=%0d required %0d", seen, lat, TO + 1);
    end
    n_cmp++;
    if (timeout_count !== 8'd1) begin
      n_bad++;
      $display("FAIL timeout_count: %0d required 1", timeout_count);
    end
    wait_idle(ok);
    nr = n_rsp;
    @(negedge clk); drp_drdy = 1'b1; drp_do = 16'hBEEF;
    @(negedge clk); drp_drdy = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (n_rsp != nr || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL late_drdy: responses=%0d busy=%b required %0d 0", n_rsp, busy, nr);
    end
  endtask

  task automatic test_race();
    int w, acc;
    bit ok;
    // drdy on the last timer cycle wins
    drp_delay = TO - 1;
    do_q.push_back(16'h0C0C);
    sb.push_back('{1, 16'h0C0C, 1'b0});
    send(1, 7'h05, 1'b0, 16'h0, w, acc);
    wait_idle(ok);
    n_cmp++;
    if (!ok || timeout_count !== 8'd1) begin
      n_bad++;
      $display("FAIL race_last_cycle: tc=%0d done=%0b required 1 1", timeout_count, ok);
    end
    // one cycle later it is a timeout and the drdy is stray
    drp_delay = TO;
    do_q.push_back(16'h7777);
    sb.push_back('{0, 16'h0000, 1'b1});
    send(0, 7'h06, 1'b0, 16'h0, w, acc);
    wait_idle(ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || timeout_count !== 8'd2) begin
      n_bad++;
      $display("FAIL race_one_late: tc=%0d done=%0b required 2 1", timeout_count, ok);
    end
  endtask

  task automatic test_reset_mid();
    int w, acc, nr;
    bit ok;
    drp_delay = -1;
    send(0, 7'h22, 1'b0, 16'h0, w, acc);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, drp_den, drp_daddr, rsp_valid, rsp_err, rsp_data, timeout_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b den=%b addr=%h rsp_valid=%b tc=%0d required all 0",
               busy, drp_den, drp_daddr, rsp_valid, timeout_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    nr = n_rsp;
    @(negedge clk); drp_drdy = 1'b1; drp_do = 16'hCAFE;
    @(negedge clk); drp_drdy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_rsp != nr || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_drdy_ignored: responses=%0d busy=%b required %0d 0", n_rsp, busy, nr);
    end
    drp_delay = 2;
    do_q.push_back(16'h00A1);
    do_q.push_back(16'h00A2);
    sb.push_back('{0, 16'h00A1, 1'b0});
    sb.push_back('{1, 16'h00A2, 1'b0});
    grant_log.delete();
    @(posedge clk); #1;
    req_addr  = {7'h31, 7'h30};
    req_valid = 2'b11;
    for (int i = 0; i < 200 && grant_log.size() < 2; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle(ok);
    n_cmp++;
    if (!ok || grant_log.size() != 2 || grant_log[0] != 0) begin
      n_bad++;
      $display("FAIL post_reset_priority: grants=%0d first=%0d done=%0b required 2 0 1",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1, ok);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_we    = '0;
    req_wdata = '0;
    drp_delay = -1;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_timeout();
    test_race();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
